// File: rtl/imager_seq_ctrl.sv
// imager_seq_ctrl
// Run controller for the simulated imager. Host configuration is captured
// into shadow registers on cfg_update and copied to the live outputs only at
// frame boundaries (run start or fv falling edge). The controller drives the
// imager enable for a programmed number of frames (or continuously), checks
// the geometry of every received frame against the live configuration, and
// reports run/frame status.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_*                   requested configuration (captured on cfg_update)
//   cfg_update              pulse: capture cfg_* into shadow, set cfg_pending
//   start, stop             run control pulses
//   num_frames              frames per run (0 = continuous), sampled at start
//   img_fv, img_lv          imager frame/line valid
//   img_enable              imager enable
//   img_mode .. img_noise_seed  live configuration
//   busy, cfg_pending       status levels
//   frames_done, err_count  status counters
//   done, frame_err         one-cycle status pulses
module imager_seq_ctrl #(
    parameter int NUM_ROWS_WIDTH  = 12,
    parameter int NUM_COLS_WIDTH  = 12,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [2:0]                 cfg_mode,
    input  logic [NUM_ROWS_WIDTH-1:0]  cfg_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]  cfg_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0]  cfg_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0]  cfg_virtual_cols,
    input  logic [31:0]                cfg_noise_seed,
    input  logic                       cfg_update,
    input  logic                       start,
    input  logic                       stop,
    input  logic [FRAME_CNT_WIDTH-1:0] num_frames,
    input  logic                       img_fv,
    input  logic                       img_lv,
    output logic                       img_enable,
    output logic [2:0]                 img_mode,
    output logic [NUM_ROWS_WIDTH-1:0]  img_active_rows,
    output logic [NUM_ROWS_WIDTH-1:0]  img_virtual_rows,
    output logic [NUM_COLS_WIDTH-1:0]  img_active_cols,
    output logic [NUM_COLS_WIDTH-1:0]  img_virtual_cols,
    output logic [31:0]                img_noise_seed,
    output logic                       busy,
    output logic                       cfg_pending,
    output logic [FRAME_CNT_WIDTH-1:0] frames_done,
    output logic                       done,
    output logic                       frame_err,
    output logic [7:0]                 err_count
);

    localparam logic [NUM_ROWS_WIDTH-1:0]  RST_ACT_ROWS = NUM_ROWS_WIDTH'(32'd4);
    localparam logic [NUM_ROWS_WIDTH-1:0]  RST_VIR_ROWS = NUM_ROWS_WIDTH'(32'd2);
    localparam logic [NUM_COLS_WIDTH-1:0]  RST_ACT_COLS = NUM_COLS_WIDTH'(32'd4);
    localparam logic [NUM_COLS_WIDTH-1:0]  RST_VIR_COLS = NUM_COLS_WIDTH'(32'd2);
    localparam logic [NUM_ROWS_WIDTH:0]    LINE_ZERO    = {(NUM_ROWS_WIDTH+1){1'b0}};
    localparam logic [NUM_ROWS_WIDTH:0]    LINE_ONE     = {{NUM_ROWS_WIDTH{1'b0}}, 1'b1};
    localparam logic [NUM_ROWS_WIDTH:0]    LINE_MAX     = {(NUM_ROWS_WIDTH+1){1'b1}};
    localparam logic [NUM_COLS_WIDTH:0]    PIX_ZERO     = {(NUM_COLS_WIDTH+1){1'b0}};
    localparam logic [NUM_COLS_WIDTH:0]    PIX_ONE      = {{NUM_COLS_WIDTH{1'b0}}, 1'b1};
    localparam logic [NUM_COLS_WIDTH:0]    PIX_MAX      = {(NUM_COLS_WIDTH+1){1'b1}};
    localparam logic [FRAME_CNT_WIDTH-1:0] FRM_ZERO     = {FRAME_CNT_WIDTH{1'b0}};
    localparam logic [FRAME_CNT_WIDTH-1:0] FRM_ONE      = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic                         r_fv_d, r_lv_d;
    logic [NUM_ROWS_WIDTH:0]      r_line_cnt, w_line_nxt, w_line_inc;
    logic [NUM_COLS_WIDTH:0]      r_pix_cnt, w_pix_nxt, w_pix_inc;
    logic                         r_frame_bad, w_bad_nxt;
    logic [FRAME_CNT_WIDTH-1:0]   r_num_frames, w_num_nxt;
    logic [FRAME_CNT_WIDTH-1:0]   r_frames_done, w_frames_nxt, w_frames_inc;
    logic [7:0]                   r_err_count, w_err_nxt;
    logic                         r_done, w_done_nxt;
    logic                         r_frame_err, w_ferr_nxt;
    logic                         r_busy;
    logic                         r_cfg_pending;
    logic                         w_apply;
    logic                         w_fv_fall, w_lv_fall, w_lv_bad, w_frame_bad_now, w_last;
    logic [2:0]                   r_sh_mode, r_img_mode;
    logic [NUM_ROWS_WIDTH-1:0]    r_sh_act_rows, r_sh_vir_rows, r_img_act_rows, r_img_vir_rows;
    logic [NUM_COLS_WIDTH-1:0]    r_sh_act_cols, r_sh_vir_cols, r_img_act_cols, r_img_vir_cols;
    logic [31:0]                  r_sh_seed, r_img_seed;

    assign w_fv_fall    = r_fv_d & ~img_fv;
    assign w_lv_fall    = r_lv_d & ~img_lv;
    assign w_pix_inc    = (r_pix_cnt == PIX_MAX) ? r_pix_cnt : (r_pix_cnt + PIX_ONE);
    // Line count including a line that ends in this very cycle, so a frame whose
    // last lv and fv fall together is still checked with all of its lines.
    assign w_line_inc   = (w_lv_fall && r_fv_d)
                          ? ((r_line_cnt == LINE_MAX) ? r_line_cnt : (r_line_cnt + LINE_ONE))
                          : r_line_cnt;
    assign w_lv_bad     = w_lv_fall && (r_pix_cnt != {1'b0, r_img_act_cols});
    assign w_frame_bad_now = r_frame_bad || w_lv_bad || (w_line_inc != {1'b0, r_img_act_rows});
    assign w_frames_inc = r_frames_done + FRM_ONE;
    assign w_last       = (r_num_frames != FRM_ZERO) && (w_frames_inc == r_num_frames);

    // Next-state and next-value logic for the run FSM and frame checker.
    always_comb begin
        w_state_nxt  = r_state;
        w_line_nxt   = r_line_cnt;
        w_pix_nxt    = r_pix_cnt;
        w_bad_nxt    = r_frame_bad;
        w_num_nxt    = r_num_frames;
        w_frames_nxt = r_frames_done;
        w_err_nxt    = r_err_count;
        w_done_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_apply      = r_cfg_pending;
                    w_num_nxt    = num_frames;
                    w_frames_nxt = FRM_ZERO;
                    w_line_nxt   = LINE_ZERO;
                    w_pix_nxt    = PIX_ZERO;
                    w_bad_nxt    = 1'b0;
                    w_state_nxt  = ST_RUN;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (img_lv) begin
                    w_pix_nxt = w_pix_inc;
                end else if (w_lv_fall) begin
                    w_pix_nxt = PIX_ZERO;
                end else begin
                    w_pix_nxt = r_pix_cnt;
                end
                w_line_nxt = w_line_inc;
                w_bad_nxt  = r_frame_bad | w_lv_bad;
                if (w_fv_fall) begin
                    w_frames_nxt = w_frames_inc;
                    if (w_frame_bad_now) begin
                        w_ferr_nxt = 1'b1;
                        w_err_nxt  = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);
                    end else begin
                        w_ferr_nxt = 1'b0;
                    end
                    w_line_nxt = LINE_ZERO;
                    w_bad_nxt  = 1'b0;
                    w_apply    = r_cfg_pending;
                    // A stop that coincides with the final frame ends the run once.
                    if ((r_state == ST_STOPPING) || w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (stop) begin
                        w_state_nxt = ST_STOPPING;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else if ((r_state == ST_RUN) && stop) begin
                    // Stop in vertical blank ends at once; otherwise finish the frame.
                    if (!img_fv && !r_fv_d) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_STOPPING;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, configuration and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fv_d         <= 1'b0;
            r_lv_d         <= 1'b0;
            r_line_cnt     <= LINE_ZERO;
            r_pix_cnt      <= PIX_ZERO;
            r_frame_bad    <= 1'b0;
            r_num_frames   <= FRM_ZERO;
            r_frames_done  <= FRM_ZERO;
            r_err_count    <= 8'd0;
            r_done         <= 1'b0;
            r_frame_err    <= 1'b0;
            r_busy         <= 1'b0;
            r_cfg_pending  <= 1'b0;
            r_sh_mode      <= 3'd0;
            r_sh_act_rows  <= RST_ACT_ROWS;
            r_sh_vir_rows  <= RST_VIR_ROWS;
            r_sh_act_cols  <= RST_ACT_COLS;
            r_sh_vir_cols  <= RST_VIR_COLS;
            r_sh_seed      <= 32'd0;
            r_img_mode     <= 3'd0;
            r_img_act_rows <= RST_ACT_ROWS;
            r_img_vir_rows <= RST_VIR_ROWS;
            r_img_act_cols <= RST_ACT_COLS;
            r_img_vir_cols <= RST_VIR_COLS;
            r_img_seed     <= 32'd0;
        end else begin
            r_fv_d        <= img_fv;
            r_lv_d        <= img_lv;
            r_line_cnt    <= w_line_nxt;
            r_pix_cnt     <= w_pix_nxt;
            r_frame_bad   <= w_bad_nxt;
            r_num_frames  <= w_num_nxt;
            r_frames_done <= w_frames_nxt;
            r_err_count   <= w_err_nxt;
            r_done        <= w_done_nxt;
            r_frame_err   <= w_ferr_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            // The old shadow is applied before a simultaneous update overwrites it.
            if (w_apply) begin
                r_img_mode     <= r_sh_mode;
                r_img_act_rows <= r_sh_act_rows;
                r_img_vir_rows <= r_sh_vir_rows;
                r_img_act_cols <= r_sh_act_cols;
                r_img_vir_cols <= r_sh_vir_cols;
                r_img_seed     <= r_sh_seed;
            end
            if (cfg_update) begin
                r_sh_mode     <= cfg_mode;
                r_sh_act_rows <= cfg_active_rows;
                r_sh_vir_rows <= cfg_virtual_rows;
                r_sh_act_cols <= cfg_active_cols;
                r_sh_vir_cols <= cfg_virtual_cols;
                r_sh_seed     <= cfg_noise_seed;
                r_cfg_pending <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pending <= 1'b0;
            end
        end
    end

    assign img_enable       = r_busy;
    assign busy             = r_busy;
    assign cfg_pending      = r_cfg_pending;
    assign frames_done      = r_frames_done;
    assign done             = r_done;
    assign frame_err        = r_frame_err;
    assign err_count        = r_err_count;
    assign img_mode         = r_img_mode;
    assign img_active_rows  = r_img_act_rows;
    assign img_virtual_rows = r_img_vir_rows;
    assign img_active_cols  = r_img_act_cols;
    assign img_virtual_cols = r_img_vir_cols;
    assign img_noise_seed   = r_img_seed;

endmodule

// File: doc/imager_seq_ctrl.md
Name: imager_seq_ctrl

Overview:
- Run controller for the simulated imager. It holds host configuration in shadow registers and applies it to the imager only at frame boundaries.
- Drives the imager enable for a programmed number of frames, or continuously.
- Checks each received frame's geometry against the live configuration and reports status to the host/testbench side.
- Sits between host register logic and the imager model's config/enable inputs; monitors the imager's fv/lv outputs.

Parameters:
NUM_ROWS_WIDTH, 12, width of row-count config fields
NUM_COLS_WIDTH, 12, width of col-count config fields
FRAME_CNT_WIDTH, 16, width of frame-count request and status

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
cfg_mode  in  3  requested imager mode
cfg_active_rows  in  NUM_ROWS_WIDTH  requested active rows
cfg_virtual_rows  in  NUM_ROWS_WIDTH  requested virtual rows
cfg_active_cols  in  NUM_COLS_WIDTH  requested active cols
cfg_virtual_cols  in  NUM_COLS_WIDTH  requested virtual cols
cfg_noise_seed  in  32  requested noise seed
cfg_update  in  1  pulse: capture cfg_* into shadow, set cfg_pending
start  in  1  pulse: begin run (ignored unless IDLE)
stop  in  1  pulse: request graceful stop
num_frames  in  FRAME_CNT_WIDTH  frames per run; 0 = continuous; sampled at start
img_fv  in  1  imager frame valid
img_lv  in  1  imager line valid
img_enable  out  1  imager enable
img_mode  out  3  live mode
img_active_rows / img_virtual_rows  out  NUM_ROWS_WIDTH  live config
img_active_cols / img_virtual_cols  out  NUM_COLS_WIDTH  live config
img_noise_seed  out  32  live seed
busy  out  1  high in RUN or STOPPING
cfg_pending  out  1  shadow not yet applied
frames_done  out  FRAME_CNT_WIDTH  frames completed this run
done  out  1  one-cycle pulse at run end
frame_err  out  1  one-cycle pulse, frame geometry mismatch
err_count  out  8  saturating mismatch count since reset

Behaviour:
- Reset values:
  - All outputs 0, except img_active_rows=4, img_active_cols=4, img_virtual_rows=2, img_virtual_cols=2.
  - Shadow registers equal to the live values; cfg_pending=0; state IDLE.
- All outputs are registered.
- fv_d/lv_d are one-cycle delayed copies of img_fv/img_lv.
  - fv_fall = fv_d & !img_fv.
  - lv_fall = lv_d & !img_lv.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - img_enable=0.
  - On start: copy shadow to live if cfg_pending (clear cfg_pending); latch num_frames; clear frames_done and the frame-check counters; go to RUN; img_enable=1 from the next cycle.
- RUN:
  - img_enable=1.
  - Line counter increments on each lv_fall while fv_d=1.
  - Pixel counter counts img_lv-high cycles, cleared at lv_fall.
  - At lv_fall: if pixel count != img_active_cols, set a per-frame error flag.
  - At fv_fall:
    - frames_done+1 (wraps at 2^FRAME_CNT_WIDTH).
    - If line count != img_active_rows or the error flag is set: frame_err pulse and err_count+1, saturating at 255.
    - Clear line counter and error flag.
    - If cfg_pending: copy shadow to live in the same cycle; clear cfg_pending.
    - If latched num_frames!=0 and frames_done+1==num_frames: img_enable=0, done pulse, go to IDLE.
  - On stop:
    - If img_fv=0 and fv_d=0: go to IDLE immediately with img_enable=0 and a done pulse.
    - Otherwise go to STOPPING.
- STOPPING:
  - img_enable stays 1; frame checking continues.
  - At the next fv_fall: count the frame, perform the checks, img_enable=0, done pulse, go to IDLE.
- Counter widths: line counter NUM_ROWS_WIDTH+1 bits, pixel counter NUM_COLS_WIDTH+1 bits; both saturate at all-ones.
- Simultaneous events:
  - cfg_update and fv_fall in the same cycle: the old shadow is applied; the new shadow is captured; cfg_pending stays 1.
  - stop and the final-frame fv_fall in the same cycle: completes normally with a single done pulse.
  - start while busy: ignored.
  - stop in IDLE: ignored.
- cfg_update is accepted in any state.
- Live config never changes while img_fv=1.
- Async reset mid-run: everything returns to reset values immediately, img_enable=0.

Test Plan:
- Reset, then cfg 4x6 active, 2x4 virtual, num_frames=3, start -> exactly 3 fv pulses; frames_done=3; done pulse once; img_enable=0; frame_err never.
- num_frames=0, run 5 frames, stop pulse mid-frame 5 -> STOPPING until fv_fall; frames_done=5; done; IDLE.
- Continuous run; cfg_update with active_cols=8 mid-frame -> img_active_cols changes at fv_fall only; cfg_pending 1→0; next frame has 8-pixel lines; no frame_err.
- Force img_lv low for one cycle inside a line (bench overrides imager) -> frame_err pulse at that frame's fv_fall; err_count=1.
- stop issued during vertical blank (fv low) -> IDLE next cycle; done pulse; no further fv.
- Assert reset_n low during an active line -> all outputs at reset values asynchronously; start after release works normally.
